cpx_mult_acc: RTL and testbench
===============================

Name: cpx_mult_acc

Overview:
Parametrised, pipelined complex multiply-accumulate. It is the successor to cpx_multiply and the correlation core for the CAF path.
- Computes x·y or x·conj(y) per beat.
- Sums ACC_LEN consecutive products.
- Emits one scaled complex result per ACC_LEN accepted beats.
- Uses the same valid/ready stream naming as cpx_multiply; backpressure stalls the whole pipeline.

Parameters:
X_BITS, 8, width of xi and xq (signed)
Y_BITS, 8, width of yi and yq (signed)
ACC_LEN, 4, products summed per output (>=1)
OUT_BITS, 19, width of i_out and q_out (signed); must be <= ACC_W
Derived (localparam): ACC_W = X_BITS+Y_BITS+1+$clog2(ACC_LEN); SHIFT = ACC_W-OUT_BITS

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
m_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  block can accept input beat
xi  input  X_BITS  x real
xq  input  X_BITS  x imag
yi  input  Y_BITS  y real
yq  input  Y_BITS  y imag
conj  input  1  1: use conj(y) for this beat; sampled with the beat
s_axis_tvalid  output  1  result valid
m_axis_tready  input  1  downstream accepts result
i_out  output  OUT_BITS  result real
q_out  output  OUT_BITS  result imag

Behaviour:
- Reset:
  - All outputs 0: s_axis_tvalid=0, i_out=0, q_out=0.
  - s_axis_tready=1 one cycle after reset deasserts; it is 0 while reset is high.
  - Pipeline valids, accumulators and beat counter are cleared.
- Pipeline enable: en = !(s_axis_tvalid && !m_axis_tready). All stages advance only when en=1.
  - s_axis_tready = en, and is 0 during reset.
  - A beat is accepted when m_axis_tvalid && s_axis_tready.
- Stage 1: register xi, xq, yi, yq, conj and valid. When conj=1, negate yq (negation done at full width Y_BITS+1, so -(-2^(Y_BITS-1)) does not overflow).
- Stage 2: four signed products xi·yi, xq·yq, xi·yq, xq·yi.
- Stage 3:
  - p_i = xi·yi - xq·yq
  - p_q = xi·yq + xq·yi
  - Both are X_BITS+Y_BITS+1 wide and sign-extended to ACC_W.
- Accumulator:
  - Beat counter 0..ACC_LEN-1, advanced only by valid stage-3 beats.
  - At count 0 the accumulator loads p; otherwise acc += p.
  - When count reaches ACC_LEN-1, the final sum goes to the output register with s_axis_tvalid=1, and the counter wraps to 0.
  - With ACC_LEN=1, every beat produces an output.
- Output scaling: i_out/q_out = acc >>> SHIFT (arithmetic, truncation toward -inf). SHIFT=0 passes the value unchanged.
- Latency: an output appears 3 cycles after the ACC_LEN-th beat is accepted, counted with no stall.
- Throughput: one beat per cycle when m_axis_tready=1. Gaps on m_axis_tvalid only insert bubbles and do not disturb the count.
- Output hold: while s_axis_tvalid=1 and m_axis_tready=0, i_out/q_out stay stable and nothing is lost.
- s_axis_tvalid drops the cycle after a handshake unless a new result is loaded that same cycle, which is allowed.
- Inputs offered while s_axis_tready=0 are not consumed; the source must hold them.
- Reset mid-accumulation discards the partial sum. The next accepted beat starts a fresh group at count 0.
- conj may change every beat; each product uses the conj sampled with its own beat.

Optional Feature:
CPX_MULT_ACC_ROUND_EN
- Defined and SHIFT>0:
  - Add 2^(SHIFT-1) to acc before the shift (round half up).
  - Saturate to the OUT_BITS signed range if the rounding carry overflows.
  - Latency is unchanged, with the extra logic in the output register stage.
- Undefined: plain truncation as in Behaviour, with no saturation logic.

Test Plan:
1. ACC_LEN=1, OUT_BITS=17, conj=0, x=3+4j, y=1+2j -> i_out=-5, q_out=10, s_axis_tvalid 3 cycles after accept.
2. Same config, conj=1, x=3+4j, y=1+2j -> 11, -2. Then x=y=-128-128j, conj=0 -> 0, 32768 with no overflow.
3. ACC_LEN=4, OUT_BITS=19, four beats x=1+1j, y=1+0j with a 2-cycle m_axis_tvalid gap mid-group -> a single output 4+4j. A fifth beat starts a new group.
4. Backpressure: streaming 1-beat groups, hold m_axis_tready=0 for 5 cycles -> i_out/q_out stable, s_axis_tready=0, no result dropped or duplicated; sequence matches the golden file.
5. ACC_LEN=1, OUT_BITS=8 (SHIFT=9), x=3+4j, y=1+2j -> -1, 0 truncated. With CPX_MULT_ACC_ROUND_EN -> 0, 0.
6. ACC_LEN=4: assert reset after 2 beats, then 4 beats of 2+0j × 1+0j -> 8+0j. The outputs were 0 during reset.

Source files
------------

// File: rtl/cpx_mult_acc.sv
// Pipelined complex multiply-accumulate: x*y or x*conj(y) per beat, ACC_LEN beats per scaled result.
// Optional build macro CPX_MULT_ACC_ROUND_EN selects round-half-up with saturation at the output stage.
module cpx_mult_acc #(
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 8,
  parameter int ACC_LEN  = 4,
  parameter int OUT_BITS = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic signed [X_BITS-1:0]   xi,
  input  logic signed [X_BITS-1:0]   xq,
  input  logic signed [Y_BITS-1:0]   yi,
  input  logic signed [Y_BITS-1:0]   yq,
  input  logic                       conj,
  output logic                       s_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic signed [OUT_BITS-1:0] i_out,
  output logic signed [OUT_BITS-1:0] q_out
);

  localparam int ACC_W = X_BITS + Y_BITS + 1 + $clog2(ACC_LEN);
  localparam int SHIFT = ACC_W - OUT_BITS;
  localparam int PW    = X_BITS + Y_BITS + 1;
  localparam int MW    = X_BITS + Y_BITS;
  localparam int YW    = Y_BITS + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

`ifdef CPX_MULT_ACC_ROUND_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1'b1) << RSH;
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'({(OUT_BITS-1){1'b1}});
`endif

  // Rounding can only carry upward, so only the positive limit needs a clamp.
  function automatic logic signed [OUT_BITS-1:0] scale(input logic signed [ACC_W-1:0] v);
`ifdef CPX_MULT_ACC_ROUND_EN
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] sh;
    wide = (ACC_W+1)'(v) + RND;
    sh   = wide >>> SHIFT;
    if (SHIFT == 0) begin
      scale = OUT_BITS'(v);
    end else if (sh > OMAX) begin
      scale = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else begin
      scale = OUT_BITS'(sh);
    end
`else
    scale = OUT_BITS'(v >>> SHIFT);
`endif
  endfunction

  logic                     rdy_q;
  logic                     en;
  logic                     accept;
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, vo_q, vo_d;
  logic signed [X_BITS-1:0] xi1_q, xi1_d, xq1_q, xq1_d;
  logic signed [Y_BITS-1:0] yi1_q, yi1_d;
  logic signed [YW-1:0]     yq1_q, yq1_d;
  logic signed [MW-1:0]     mii_q, mii_d, mqi_q, mqi_d;
  logic signed [PW-1:0]     mqq_q, mqq_d, miq_q, miq_d;
  logic signed [PW-1:0]     pi3_q, pi3_d, pq3_q, pq3_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0]  sum_i, sum_q;
  logic signed [OUT_BITS-1:0] io_q, io_d, qo_q, qo_d;
  logic                     last;

  assign s_axis_tready = rdy_q && en;
  assign s_axis_tvalid = vo_q;
  assign i_out         = io_q;
  assign q_out         = qo_q;

  // Next-state for every pipeline stage; a held result freezes the whole pipe.
  always_comb begin
    en      = !(vo_q && !m_axis_tready);
    accept  = m_axis_tvalid && rdy_q && en;
    v1_d = v1_q;  xi1_d = xi1_q;  xq1_d = xq1_q;  yi1_d = yi1_q;  yq1_d = yq1_q;
    v2_d = v2_q;  mii_d = mii_q;  mqq_d = mqq_q;  miq_d = miq_q;  mqi_d = mqi_q;
    v3_d = v3_q;  pi3_d = pi3_q;  pq3_d = pq3_q;
    cnt_d = cnt_q;  acc_i_d = acc_i_q;  acc_q_d = acc_q_q;
    vo_d = vo_q;  io_d = io_q;  qo_d = qo_q;
    last  = (cnt_q == CNT_W'(ACC_LEN - 1));
    sum_i = (cnt_q == '0) ? ACC_W'(pi3_q) : acc_i_q + ACC_W'(pi3_q);
    sum_q = (cnt_q == '0) ? ACC_W'(pq3_q) : acc_q_q + ACC_W'(pq3_q);
    if (en) begin
      v1_d  = accept;
      xi1_d = xi;
      xq1_d = xq;
      yi1_d = yi;
      // One extra bit so negating the most negative yq cannot wrap.
      yq1_d = conj ? -(YW'(yq)) : YW'(yq);
      v2_d  = v1_q;
      mii_d = MW'(xi1_q) * MW'(yi1_q);
      mqq_d = PW'(xq1_q) * PW'(yq1_q);
      miq_d = PW'(xi1_q) * PW'(yq1_q);
      mqi_d = MW'(xq1_q) * MW'(yi1_q);
      v3_d  = v2_q;
      pi3_d = PW'(mii_q) - mqq_q;
      pq3_d = miq_q + PW'(mqi_q);
      vo_d  = 1'b0;
      if (v3_q) begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        if (last) begin
          cnt_d = '0;
          vo_d  = 1'b1;
          io_d  = scale(sum_i);
          qo_d  = scale(sum_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      vo_d = vo_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
      v1_q <= 1'b0;  xi1_q <= '0;  xq1_q <= '0;  yi1_q <= '0;  yq1_q <= '0;
      v2_q <= 1'b0;  mii_q <= '0;  mqq_q <= '0;  miq_q <= '0;  mqi_q <= '0;
      v3_q <= 1'b0;  pi3_q <= '0;  pq3_q <= '0;
      cnt_q <= '0;  acc_i_q <= '0;  acc_q_q <= '0;
      vo_q <= 1'b0;  io_q <= '0;  qo_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      v1_q <= v1_d;  xi1_q <= xi1_d;  xq1_q <= xq1_d;  yi1_q <= yi1_d;  yq1_q <= yq1_d;
      v2_q <= v2_d;  mii_q <= mii_d;  mqq_q <= mqq_d;  miq_q <= miq_d;  mqi_q <= mqi_d;
      v3_q <= v3_d;  pi3_q <= pi3_d;  pq3_q <= pq3_d;
      cnt_q <= cnt_d;  acc_i_q <= acc_i_d;  acc_q_q <= acc_q_d;
      vo_q <= vo_d;  io_q <= io_d;  qo_q <= qo_d;
    end
  end

endmodule

// File: tb/tb_cpx_mult_acc.sv
// Directed bench for cpx_mult_acc: three instances cover ACC_LEN=1/OUT_BITS=17,
// ACC_LEN=4/OUT_BITS=19 and ACC_LEN=1/OUT_BITS=8; all share the input stream.
module tb_cpx_mult_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, m_axis_tvalid = 1'b0, m_axis_tready = 1'b1, conj = 1'b0;
  logic signed [7:0] xi = '0, xq = '0, yi = '0, yq = '0;
  logic ra, va, rb, vb, rc, vc;
  logic signed [16:0] ia, qa;
  logic signed [18:0] ib, qb;
  logic signed [7:0]  ic, qc;

  int sel = 0;
  logic rdy_sel, v_sel;
  logic signed [19:0] i_sel, q_sel;
  int n_chk = 0, n_pass = 0;

  logic mon_en = 1'b0;
  logic signed [19:0] got_i[$], got_q[$];

  cpx_mult_acc #(.X_BITS(8), .Y_BITS(8), .ACC_LEN(1), .OUT_BITS(17)) u_a (
    .clk(clk), .reset(reset), .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(ra),
    .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj),
    .s_axis_tvalid(va), .m_axis_tready(m_axis_tready), .i_out(ia), .q_out(qa));
  cpx_mult_acc #(.X_BITS(8), .Y_BITS(8), .ACC_LEN(4), .OUT_BITS(19)) u_b (
    .clk(clk), .reset(reset), .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(rb),
    .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj),
    .s_axis_tvalid(vb), .m_axis_tready(m_axis_tready), .i_out(ib), .q_out(qb));
  cpx_mult_acc #(.X_BITS(8), .Y_BITS(8), .ACC_LEN(1), .OUT_BITS(8)) u_c (
    .clk(clk), .reset(reset), .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(rc),
    .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj),
    .s_axis_tvalid(vc), .m_axis_tready(m_axis_tready), .i_out(ic), .q_out(qc));

  always_comb begin
    case (sel)
      0:       begin rdy_sel = ra; v_sel = va; i_sel = 20'(ia); q_sel = 20'(qa); end
      1:       begin rdy_sel = rb; v_sel = vb; i_sel = 20'(ib); q_sel = 20'(qb); end
      default: begin rdy_sel = rc; v_sel = vc; i_sel = 20'(ic); q_sel = 20'(qc); end
    endcase
  end

  // Records every result handshake of the selected instance.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && v_sel && m_axis_tready) begin
      got_i.push_back(i_sel);
      got_q.push_back(q_sel);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    m_axis_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input int c, input int d, input logic cj);
    logic ok;
    ok = 1'b0;
    xi = 8'(a); xq = 8'(b); yi = 8'(c); yq = 8'(d); conj = cj;
    m_axis_tvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1 ok = rdy_sel;
      @(negedge clk);
      if (ok) break;
    end
    m_axis_tvalid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: beat not accepted, ready=%b required 1", rdy_sel);
    end
  endtask

  task automatic wait_valid(input int max);
    for (int t = 0; t < max; t++) begin
      #1;
      if (v_sel) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++;
    if ({va, vb, vc, ra, rb, rc} !== 6'b0) $display("FAIL reset_flags: got %b required 000000", {va, vb, vc, ra, rb, rc});
    else n_pass++;
    n_chk++;
    if (ia !== 17'sd0 || qa !== 17'sd0 || ib !== 19'sd0 || qb !== 19'sd0 || ic !== 8'sd0 || qc !== 8'sd0)
      $display("FAIL reset_data: got %0d %0d %0d %0d %0d %0d required all 0", ia, qa, ib, qb, ic, qc);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (ra !== 1'b0) $display("FAIL reset_ready_early: got %b required 0", ra);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({ra, rb, rc} !== 3'b111) $display("FAIL reset_ready_late: got %b required 111", {ra, rb, rc});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mult_latency();
    sel = 0;
    do_reset();
    send(3, 4, 1, 2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (va !== 1'b0) $display("FAIL latency_early: valid=%b required 0 two cycles after accept", va);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (va !== 1'b1 || ia !== -17'sd5 || qa !== 17'sd10)
      $display("FAIL mult_basic: got v=%b %0d,%0d required v=1 -5,10", va, ia, qa);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_conj_extreme();
    sel = 0;
    send(3, 4, 1, 2, 1'b1);
    wait_valid(10);
    n_chk++;
    if (v_sel !== 1'b1 || i_sel !== 20'sd11 || q_sel !== -20'sd2)
      $display("FAIL mult_conj: got v=%b %0d,%0d required 11,-2", v_sel, i_sel, q_sel);
    else n_pass++;
    @(negedge clk);
    send(-128, -128, -128, -128, 1'b0);
    wait_valid(10);
    n_chk++;
    if (v_sel !== 1'b1 || i_sel !== 20'sd0 || q_sel !== 20'sd32768)
      $display("FAIL mult_extreme: got v=%b %0d,%0d required 0,32768", v_sel, i_sel, q_sel);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_scaling();
    logic signed [19:0] e1i, e1q, e2i, e2q;
`ifdef CPX_MULT_ACC_ROUND_EN
    e1i = 20'sd0; e1q = 20'sd0; e2i = 20'sd0; e2q = 20'sd0;
`else
    e1i = -20'sd1; e1q = 20'sd0; e2i = 20'sd0; e2q = -20'sd1;
`endif
    sel = 2;
    do_reset();
    send(3, 4, 1, 2, 1'b0);
    wait_valid(10);
    n_chk++;
    if (v_sel !== 1'b1 || i_sel !== e1i || q_sel !== e1q)
      $display("FAIL scale_small: got %0d,%0d required %0d,%0d", i_sel, q_sel, e1i, e1q);
    else n_pass++;
    @(negedge clk);
    send(3, 4, 1, 2, 1'b1);
    wait_valid(10);
    n_chk++;
    if (v_sel !== 1'b1 || i_sel !== e2i || q_sel !== e2q)
      $display("FAIL scale_conj: got %0d,%0d required %0d,%0d", i_sel, q_sel, e2i, e2q);
    else n_pass++;
    @(negedge clk);
    send(-128, -128, -128, -128, 1'b0);
    wait_valid(10);
    n_chk++;
    if (v_sel !== 1'b1 || i_sel !== 20'sd0 || q_sel !== 20'sd64)
      $display("FAIL scale_large: got %0d,%0d required 0,64", i_sel, q_sel);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic signed [16:0] hold_i, hold_q;
    sel = 0;
    do_reset();
    got_i.delete();
    got_q.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int k = 1; k <= 8; k++) send(k, 0, 2, 1, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        m_axis_tready = 1'b0;
        #1;
        hold_i = ia;
        hold_q = qa;
        for (int k = 0; k < 5; k++) begin
          #1;
          n_chk++;
          if (va !== 1'b1 || ra !== 1'b0 || ia !== hold_i || qa !== hold_q)
            $display("FAIL stall_hold[%0d]: got v=%b rdy=%b %0d,%0d required v=1 rdy=0 %0d,%0d",
                     k, va, ra, ia, qa, hold_i, hold_q);
          else n_pass++;
          @(negedge clk);
        end
        m_axis_tready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    n_chk++;
    if (got_i.size() != 8) $display("FAIL stream_count: got %0d results required 8", got_i.size());
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (got_i[k] !== 20'(2 * (k + 1)) || got_q[k] !== 20'(k + 1))
        $display("FAIL stream[%0d]: got %0d,%0d required %0d,%0d", k, got_i[k], got_q[k], 2 * (k + 1), k + 1);
      else n_pass++;
    end
  endtask

  task automatic test_accumulate();
    logic seen;
    sel = 1;
    do_reset();
    send(1, 1, 1, 0, 1'b0);
    send(1, 1, 1, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    send(1, 1, 1, 0, 1'b0);
    send(1, 1, 1, 0, 1'b0);
    wait_valid(12);
    n_chk++;
    if (vb !== 1'b1 || ib !== 19'sd4 || qb !== 19'sd4)
      $display("FAIL acc_group: got v=%b %0d,%0d required 4,4", vb, ib, qb);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (vb !== 1'b0) $display("FAIL acc_drop: valid=%b required 0 after handshake", vb);
    else n_pass++;
    @(negedge clk);
    send(2, -3, 1, 1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (vb) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL acc_partial: output after 1 beat of new group, seen=%b required 0", seen);
    else n_pass++;
    @(negedge clk);
    for (int k = 0; k < 3; k++) send(2, -3, 1, 1, 1'b1);
    wait_valid(12);
    n_chk++;
    if (vb !== 1'b1 || ib !== -19'sd4 || qb !== -19'sd20)
      $display("FAIL acc_group2: got v=%b %0d,%0d required -4,-20", vb, ib, qb);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sel = 1;
    send(5, 5, 1, 0, 1'b0);
    send(5, 5, 1, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if (vb !== 1'b0 || rb !== 1'b0 || ib !== 19'sd0 || qb !== 19'sd0)
      $display("FAIL mid_reset_out: got v=%b rdy=%b %0d,%0d required 0 0 0,0", vb, rb, ib, qb);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(2, 0, 1, 0, 1'b0);
    wait_valid(12);
    n_chk++;
    if (vb !== 1'b1 || ib !== 19'sd8 || qb !== 19'sd0)
      $display("FAIL mid_reset_group: got v=%b %0d,%0d required 8,0", vb, ib, qb);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult_latency();
    test_conj_extreme();
    test_scaling();
    test_back_to_back();
    test_accumulate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
